// File: rtl/sensor_seq_pkg.sv
// Shared definitions for the sensor crossing sequence driver: state encoding,
// acknowledge code and counter width.
package sensor_seq_pkg;

    localparam logic [3:0] ST_IDLE     = 4'd0;
    localparam logic [3:0] ST_FIRST    = 4'd1;
    localparam logic [3:0] ST_GAP1     = 4'd2;
    localparam logic [3:0] ST_INTENT   = 4'd3;
    localparam logic [3:0] ST_GAP2     = 4'd4;
    localparam logic [3:0] ST_SECOND   = 4'd5;
    localparam logic [3:0] ST_WAIT_ACK = 4'd6;
    localparam logic [3:0] ST_DONE     = 4'd7;
    localparam logic [3:0] ST_ERR      = 4'd8;

    // Status code returned by the sensor FSM once it has seen the whole sequence.
    localparam logic [1:0] CA_ACK = 2'b11;

    // Width of the gap and timeout counters (TIMEOUT up to 255).
    localparam int CNT_W = 8;

    typedef enum logic [3:0] {
        IDLE     = ST_IDLE,
        FIRST    = ST_FIRST,
        GAP1     = ST_GAP1,
        INTENT   = ST_INTENT,
        GAP2     = ST_GAP2,
        SECOND   = ST_SECOND,
        WAIT_ACK = ST_WAIT_ACK,
        DONE     = ST_DONE,
        ERR      = ST_ERR
    } state_e;

endpackage

// File: rtl/sensor_seq_driver_if.sv
// Request/response bundle between a sequence requester and the sensor driver.
interface sensor_seq_driver_if;
    logic       start;
    logic       order;
    logic [3:0] gap;
    logic [1:0] ca_in;
    logic       c1;
    logic       c2;
    logic       i;
    logic       busy;
    logic       done;
    logic       err;

    // Requester side: issues start/order/gap and returns the sensor status.
    modport master (
        output start, order, gap, ca_in,
        input  c1, c2, i, busy, done, err
    );

    // Driver side.
    modport slave (
        input  start, order, gap, ca_in,
        output c1, c2, i, busy, done, err
    );
endinterface

// File: rtl/seq_counter.sv
// Up-counter with synchronous clear, count enable and terminal-count compare.
// tc_o compares the registered count, so it never depends on clr_i/en_i.
module seq_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic [W-1:0] term_i,
    output logic         tc_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: clear wins over enable.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == term_i);

endmodule

// File: rtl/sensor_seq_driver.sv
// Drives one crossing sequence onto sensors C1/C2: first pulse, intent pulse,
// second pulse, separated by a programmable gap, then waits for the sensor FSM
// to acknowledge or times out. All outputs are decoded from state alone.
module sensor_seq_driver
    import sensor_seq_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic                clk,
    input  logic                rst,
    sensor_seq_driver_if.slave  bus
);

    localparam logic [CNT_W-1:0] TO_TERM = CNT_W'(TIMEOUT - 1);

    state_e     state_q, state_d;
    logic       order_q, order_d;
    logic [3:0] gap_q,   gap_d;

    logic             entering;
    logic             gap_tc;
    logic             to_tc;
    logic [CNT_W-1:0] gap_term;

    // A GAP state lasting gap_q cycles ends when its count reaches gap_q-1.
    // With gap_q == 0 the GAP states are skipped, so the wrapped value is unused.
    assign gap_term = {4'd0, gap_q} - CNT_W'(1);

    // Both counters restart whenever the FSM moves to a different state.
    assign entering = (state_d != state_q);

    seq_counter #(.W(CNT_W)) u_gap_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (entering),
        .en_i   ((state_q == GAP1) || (state_q == GAP2)),
        .term_i (gap_term),
        .tc_o   (gap_tc)
    );

    seq_counter #(.W(CNT_W)) u_to_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (entering),
        .en_i   (state_q == WAIT_ACK),
        .term_i (TO_TERM),
        .tc_o   (to_tc)
    );

    // Next-state logic and capture of order/gap when a sequence is accepted.
    always_comb begin
        state_d = state_q;
        order_d = order_q;
        gap_d   = gap_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    order_d = bus.order;
                    gap_d   = bus.gap;
                    state_d = FIRST;
                end
            end
            FIRST:    state_d = (gap_q == 4'd0) ? INTENT : GAP1;
            GAP1:     if (gap_tc) state_d = INTENT;
            INTENT:   state_d = (gap_q == 4'd0) ? SECOND : GAP2;
            GAP2:     if (gap_tc) state_d = SECOND;
            SECOND:   state_d = WAIT_ACK;
            WAIT_ACK: begin
                // An acknowledge in the last allowed cycle still counts.
                if (bus.ca_in == CA_ACK) begin
                    state_d = DONE;
                end else if (to_tc) begin
                    state_d = ERR;
                end
            end
            DONE:     state_d = IDLE;
            ERR:      state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // State and latched sequence parameters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            order_q <= 1'b0;
            gap_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            order_q <= order_d;
            gap_q   <= gap_d;
        end
    end

    // Moore output decode.
    assign bus.c1   = ((state_q == FIRST) && !order_q) || ((state_q == SECOND) && order_q);
    assign bus.c2   = ((state_q == FIRST) && order_q)  || ((state_q == SECOND) && !order_q);
    assign bus.i    = (state_q == INTENT);
    assign bus.busy = (state_q != IDLE);
    assign bus.done = (state_q == DONE);
    assign bus.err  = (state_q == ERR);

endmodule

// File: doc/sensor_seq_driver.md
SENSOR_SEQ_DRIVER -- requirements
Module: sensor_seq_driver

Interface
REQ-001 Parameter: TIMEOUT, default 64, number of WAIT_ACK cycles allowed before error (legal 1..255).
REQ-002 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 Port: rst  input  1  asynchronous, active-high reset.
REQ-004 Port: start  input  1  request to run one crossing sequence; sampled only in IDLE.
REQ-005 Port: order  input  1  0 = C1 sensor first, 1 = C2 sensor first; latched with start.
REQ-006 Port: gap  input  4  idle cycles inserted between consecutive pulses; latched with start.
REQ-007 Port: ca_in  input  2  status code fed back from the sensor FSM; 2'b11 = sequence acknowledged.
REQ-008 Port: c1  output  1  one-cycle pulse driving sensor C1.
REQ-009 Port: c2  output  1  one-cycle pulse driving sensor C2.
REQ-010 Port: i  output  1  one-cycle intent pulse.
REQ-011 Port: busy  output  1  high in every state except IDLE.
REQ-012 Port: done  output  1  one-cycle pulse on successful acknowledge.
REQ-013 Port: err  output  1  one-cycle pulse on acknowledge timeout.

Function
REQ-014 The FSM SHALL have states IDLE, FIRST, GAP1, INTENT, GAP2, SECOND, WAIT_ACK, DONE, ERR.
REQ-015 All outputs SHALL be Moore-decoded from state only; no combinational path from any input to any output.
REQ-016 IDLE with start=1 SHALL latch order and gap and go to FIRST; start=0 stays IDLE.
REQ-017 FIRST SHALL assert c1 (order=0) or c2 (order=1) for exactly one cycle, then go to GAP1, or INTENT if gap=0.
REQ-018 GAP1/GAP2 SHALL each last exactly gap cycles with all pulse outputs low.
REQ-019 INTENT SHALL assert i for one cycle, then go to GAP2, or SECOND if gap=0.
REQ-020 SECOND SHALL pulse the sensor not pulsed in FIRST for one cycle, then go to WAIT_ACK.
REQ-021 WAIT_ACK SHALL go to DONE the cycle ca_in==2'b11 is sampled; otherwise after TIMEOUT cycles without it SHALL go to ERR.
REQ-022 ca_in==2'b11 sampled in the final timeout cycle SHALL take priority: DONE, not ERR.
REQ-023 DONE asserts done, ERR asserts err, each for one cycle, then returns to IDLE.
REQ-024 start asserted while busy=1 SHALL be ignored and not queued.
REQ-025 Timing: start sampled at edge k gives first pulse in cycle k+1, i in cycle k+2+gap, second pulse in cycle k+3+2*gap.
REQ-026 Gap and timeout counters SHALL clear on every state entry; ca_in is ignored outside WAIT_ACK.

Reset
REQ-027 rst=1 SHALL immediately force state IDLE, counters 0, latched order/gap 0, all outputs 0, including mid-sequence.
REQ-028 After rst deasserts, the first start is accepted on the next rising edge.

Structure
REQ-029 Shared package sensor_seq_pkg SHALL hold the state encoding localparams and CA_ACK=2'b11.
REQ-030 One sub-module seq_counter (8-bit, clear/enable, terminal-count compare) SHALL be instantiated for the gap count and one for the timeout count.

Verification
REQ-031 order=0, gap=0, start at cycle 0 -> c1 in cycle 1, i in cycle 2, c2 in cycle 3; ca_in=11 at cycle 5 -> done in cycle 6, IDLE in cycle 7.
REQ-032 order=1, gap=3 -> c2 in cycle 1, i in cycle 5, c1 in cycle 9, busy high from cycle 1 until IDLE.
REQ-033 TIMEOUT=4, ca_in held 00 -> err pulses one cycle after the 4th WAIT_ACK cycle, done never asserts.
REQ-034 TIMEOUT=4, ca_in=11 only in the 4th WAIT_ACK cycle -> done asserts, err stays 0.
REQ-035 rst pulsed during GAP2 -> all outputs 0 immediately; a new start with order=1 produces c2 first.
REQ-036 start held high throughout a run -> no extra pulses mid-run; a new sequence begins the cycle after return to IDLE.
